// File: rtl/idct_pkg.sv
// Shared constants and helpers for the IDCT front end and core: word width,
// block size, JPEG zig-zag scan table and 16-bit saturation.
package idct_pkg;

    localparam int ML  = 16;
    localparam int BLK = 64;

    // zz[k] = natural (row-major) index of zig-zag scan position k
    localparam logic [5:0] zz [0:BLK-1] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL
    } bank_state_t;

    function automatic logic signed [ML-1:0] sat16(input logic signed [24:0] v);
        if (v > 25'sd32767)
            return 16'sh7fff;
        else if (v < -25'sd32768)
            return 16'sh8000;
        else
            return v[ML-1:0];
    endfunction

endpackage

// File: rtl/coef_bank.sv
// One 8x8 coefficient bank: 64 words plus a written-mask so that positions
// never written in the current block read back as zero.
module coef_bank
    import idct_pkg::*;
#(
    parameter int ML = idct_pkg::ML
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_clr,
    input  logic                 i_we,
    input  logic [5:0]           i_idx,
    input  logic signed [ML-1:0] i_data,
    output logic [ML*BLK-1:0]    o_data
);

    logic signed [ML-1:0] r_mem [BLK];
    logic [BLK-1:0]       r_mask;
    logic [BLK-1:0]       w_set;

    assign w_set = i_we ? (BLK'(1) << i_idx) : '0;

    // Clear and first write can coincide: the new block keeps only that bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_mask <= '0;
        else if (i_clr || i_we)
            r_mask <= (i_clr ? '0 : r_mask) | w_set;
    end

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_idx] <= i_data;
    end

    always_comb begin
        o_data = '0;
        for (int n = 0; n < BLK; n++)
            o_data[n*ML +: ML] = r_mask[n] ? r_mem[n] : '0;
    end

endmodule

// File: rtl/idct_block_loader.sv
// Zig-zag coefficient loader: dequantizes each beat, scatters it into natural
// order in a ping-pong bank pair, and presents finished blocks to the IDCT.
module idct_block_loader
    import idct_pkg::*;
#(
    parameter int ML = idct_pkg::ML,
    parameter int QW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [ML-1:0] in_data,
    input  logic                 in_eob,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 q_we,
    input  logic [5:0]           q_addr,
    input  logic [QW-1:0]        q_data,
    output logic [ML*BLK-1:0]    out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int PW = ML + QW + 1;

    bank_state_t          r_state [2];
    bank_state_t          w_state_nxt [2];
    logic                 r_wptr;
    logic                 r_rptr;
    logic [5:0]           r_k;
    logic [QW-1:0]        r_q [BLK];

    logic                 w_acc;
    logic                 w_done;
    logic                 w_pop;
    logic signed [PW-1:0] w_prod;
    logic signed [ML-1:0] w_coef;
    logic [5:0]           w_nat;
    logic [ML*BLK-1:0]    w_bank_data [2];

    assign in_ready  = (r_state[r_wptr] != BANK_FULL);
    assign out_valid = (r_state[r_rptr] == BANK_FULL);
    assign w_acc     = in_valid && in_ready;
    assign w_done    = w_acc && (in_eob || (r_k == 6'd63));
    assign w_pop     = out_valid && out_ready;

    // Quantizer entry is unsigned: zero-extend before the signed multiply.
    assign w_prod = PW'(in_data) * PW'($signed({1'b0, r_q[r_k]}));
    assign w_coef = sat16(w_prod);
    assign w_nat  = zz[r_k];

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_state_nxt[b] = r_state[b];
            if (w_pop && (r_rptr == 1'(b)))
                w_state_nxt[b] = BANK_EMPTY;
            if (w_acc && (r_wptr == 1'(b)))
                w_state_nxt[b] = w_done ? BANK_FULL : BANK_FILLING;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state[0] <= BANK_EMPTY;
            r_state[1] <= BANK_EMPTY;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_k        <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_acc)
                r_k <= w_done ? 6'd0 : r_k + 6'd1;
            if (w_done)
                r_wptr <= ~r_wptr;
            if (w_pop)
                r_rptr <= ~r_rptr;
        end
    end

    // Table resets to identity; a write lands after this cycle's product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BLK; i++)
                r_q[i] <= QW'(1);
        end else if (q_we) begin
            r_q[q_addr] <= q_data;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic w_sel;
        assign w_sel = w_acc && (r_wptr == 1'(b));

        coef_bank #(.ML(ML)) u_bank (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_clr  (w_sel && (r_state[b] == BANK_EMPTY)),
            .i_we   (w_sel),
            .i_idx  (w_nat),
            .i_data (w_coef),
            .o_data (w_bank_data[b])
        );
    end

    assign out_data = r_rptr ? w_bank_data[1] : w_bank_data[0];

endmodule

// File: tb/tb_idct_block_loader.sv
// Directed bench for idct_block_loader with a block scoreboard fed by a
// bench-side dequantize/zig-zag model.
module tb_idct_block_loader;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [15:0] in_data;
    logic               in_eob;
    logic               in_valid;
    logic               in_ready;
    logic               q_we;
    logic [5:0]         q_addr;
    logic [7:0]         q_data;
    logic [1023:0]      out_data;
    logic               out_valid;
    logic               out_ready;

    int            n_asrt = 0;
    int            n_fail = 0;
    int            zzt [64];
    int            zi;
    logic [7:0]    tq [64];
    int            kk;
    logic [1023:0] cur;
    logic [1023:0] sb [$];

    idct_block_loader #(.ML(16), .QW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_eob    (in_eob),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q_we      (q_we),
        .q_addr    (q_addr),
        .q_data    (q_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] bsat(input int p);
        if (p > 32767)  return 16'h7fff;
        if (p < -32768) return 16'h8000;
        return p[15:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) tq[i] = 8'd1;
        kk  = 0;
        cur = '0;
        sb.delete();
    endtask

    task automatic beat(input logic [15:0] d, input bit eob);
        int w;
        int p;
        in_valid = 1'b1;
        in_data  = d;
        in_eob   = eob;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 300) begin
            w++;
            @(negedge clk);
        end
        chk("beat_accept", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        p = int'($signed(d)) * int'(tq[kk]);
        cur[zzt[kk]*16 +: 16] = bsat(p);
        if (eob || kk == 63) begin
            sb.push_back(cur);
            cur = '0;
            kk  = 0;
        end else begin
            kk++;
        end
        in_valid = 1'b0;
        in_eob   = 1'b0;
    endtask

    task automatic qwrite(input logic [5:0] a, input logic [7:0] v);
        q_we   = 1'b1;
        q_addr = a;
        q_data = v;
        @(posedge clk);
        #1;
        q_we  = 1'b0;
        tq[a] = v;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sb.size() > 0; i++) @(posedge clk);
        #1;
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    // Compare every block the DUT hands over against the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_asrt++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_block: observed extra block expected none");
            end
            if (sb.size() != 0) begin
                logic [1023:0] e;
                int bad;
                e   = sb.pop_front();
                bad = -1;
                for (int n = 63; n >= 0; n--)
                    if (out_data[n*16 +: 16] !== e[n*16 +: 16]) bad = n;
                n_asrt++;
                assert (out_data === e) else begin
                    n_fail++;
                    $error("FAIL block_data: idx %0d observed %0h expected %0h",
                           bad, out_data[bad*16 +: 16], e[bad*16 +: 16]);
                end
            end
        end
    end

    initial begin
        zi = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0) begin
                for (int r = (s < 8 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
                    zzt[zi] = r * 8 + (s - r);
                    zi++;
                end
            end else begin
                for (int r = (s > 7 ? s - 7 : 0); r <= (s < 8 ? s : 7); r++) begin
                    zzt[zi] = r * 8 + (s - r);
                    zi++;
                end
            end
        end

        rst_n = 1'b0; in_data = '0; in_eob = 1'b0; in_valid = 1'b0;
        q_we = 1'b0; q_addr = '0; q_data = '0; out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data_zero", 64'(|out_data), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Identity quant, beats 1..64
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            beat(16'(i + 1), 1'b0);
            if (i == 62) chk("ident_not_early", 64'(out_valid), 64'd0);
        end
        chk("ident_out_valid", 64'(out_valid), 64'd1);
        chk("ident_idx8", 64'(out_data[8*16 +: 16]), 64'd3);
        chk("ident_idx63", 64'(out_data[63*16 +: 16]), 64'd64);
        drain();

        // DC-only block with q[0]=16
        qwrite(6'd0, 8'd16);
        beat(16'd5, 1'b1);
        chk("dc_idx0", 64'(out_data[15:0]), 64'd80);
        chk("dc_rest_zero", 64'(|out_data[1023:16]), 64'd0);
        drain();

        // Saturation at k=1 with q[1]=255
        qwrite(6'd1, 8'd255);
        beat(16'd0, 1'b0);
        beat(16'd1000, 1'b1);
        chk("sat_pos", 64'(out_data[16 +: 16]), 64'h7fff);
        beat(16'd0, 1'b0);
        beat(-16'sd1000, 1'b1);
        chk("sat_neg", 64'(out_data[16 +: 16]), 64'h8000);
        drain();

        // Completion coinciding with output handshake
        beat(16'd1, 1'b1);
        beat(-16'sd2, 1'b1);
        beat(16'd3, 1'b1);
        drain();

        // Backpressure: both banks fill, one-cycle release
        out_ready = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 64; i++)
                beat(16'($urandom_range(0, 65535)), 1'b0);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        repeat (3) @(negedge clk);
        chk("bp_in_ready_held", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_in_ready_rise", 64'(in_ready), 64'd1);
        chk("bp_second_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 64; i++)
            beat(16'($urandom_range(0, 65535)), 1'b0);
        chk("bp_full_again", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        drain();

        // Reset mid-block discards the partial block and the quant table
        for (int i = 0; i < 30; i++)
            beat(16'($urandom_range(1, 60000)), 1'b0);
        rst_n = 1'b0;
        #3;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_data", 64'(|out_data), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 64; i++)
            beat(16'($urandom_range(0, 65535)), 1'b0);
        chk("postrst_idx0_identity", 64'(out_data[15:0]), 64'(sb[0][15:0]));
        drain();

        // Quant write coinciding with its use at k=2
        beat(16'd7, 1'b0);
        beat(16'd7, 1'b0);
        q_we = 1'b1; q_addr = 6'd2; q_data = 8'd9;
        beat(16'd7, 1'b0);
        q_we  = 1'b0;
        tq[2] = 8'd9;
        beat(16'd7, 1'b1);
        chk("qcoll_old_value", 64'(out_data[8*16 +: 16]), 64'd7);
        beat(16'd7, 1'b0);
        beat(16'd7, 1'b0);
        beat(16'd7, 1'b1);
        chk("qcoll_new_value", 64'(out_data[8*16 +: 16]), 64'd63);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
